fft_io_streamer: RTL and testbench

//  IO-side master of the RAM_TOP io_* port pair. Accepts a stream of N complex samples
//  (valid/ready), writes them into the complex sample RAM two per write, and pulses
//  fft_start. On fft_done it reads the N results back and emits them as a valid/ready stream.

---
 rtl/fft_pkg.sv | 36 +++
 rtl/fft_io_streamer_addr_bitrev.sv | 21 ++
 rtl/fft_io_streamer.sv | 165 ++++++++++++++++
 tb/tb_fft_io_streamer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared types and helpers for the FFT IO streamer.
//   state_t            : streamer FSM states
//   WORD_SIZE_DEFAULT  : default bits per real/imag part
//   SAMPLE_W_DEFAULT   : default complex sample width {re,im}
//   BITREV_MAX_W       : widest address the bitrev() helper handles
//   bitrev(addr, aw)   : reverse the low aw bits of addr
// ---------------------------------------------------------------------------
package fft_pkg;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_KICK    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_FETCH   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_EMIT    = 3'd5
    } state_t;

    localparam int WORD_SIZE_DEFAULT = 16;
    localparam int SAMPLE_W_DEFAULT  = 2 * WORD_SIZE_DEFAULT;
    localparam int BITREV_MAX_W      = 16;

    // Bits at or above aw are returned as zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] addr,
                                                        input int aw);
        logic [BITREV_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            if (i < aw) r[i] = addr[aw-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_io_streamer_addr_bitrev.sv
// ---------------------------------------------------------------------------
// addr_bitrev
// Combinational AW-bit address bit reversal.
//   addr : natural-order address
//   rev  : addr with its AW bits mirrored
// ---------------------------------------------------------------------------
module addr_bitrev
    import fft_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] addr,
    output logic [AW-1:0] rev
);

    logic [BITREV_MAX_W-1:0] wide;

    assign wide = bitrev(BITREV_MAX_W'(addr), AW);
    assign rev  = wide[AW-1:0];

endmodule

// File: rtl/fft_io_streamer.sv
// ---------------------------------------------------------------------------
// fft_io_streamer
// IO-side master of the sample RAM. Loads N input samples (two per RAM
// write), pulses fft_start, waits for fft_done, then reads the N results
// back in natural order and emits them as a stream. One frame in flight.
// Ports:
//   clk, reset                 : clock, async active-high reset
//   in_valid/in_ready/in_sample: input sample stream
//   out_valid/out_ready/out_sample : result stream
//   fft_start (out), fft_busy/fft_done (in) : FFT engine control
//   io_wr_en, io_wr_address1/2, io_wr_sample1/2 : RAM pair write
//   io_rd_address1/2 (out), io_rd_sample1/2 (in) : RAM pair read, 1-cycle latency
//   frame_busy                 : high unless idle in LOAD with nothing buffered
//   state_dbg                  : current FSM state
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; a source holds valid and its data stable until that edge.
// ---------------------------------------------------------------------------
module fft_io_streamer
    import fft_pkg::*;
#(
    parameter int N             = 32,
    parameter int word_size     = WORD_SIZE_DEFAULT,
    parameter int address_width = $clog2(N),
    parameter bit BIT_REVERSE   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*word_size-1:0]   in_sample,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*word_size-1:0]   out_sample,
    output logic                     fft_start,
    input  logic                     fft_busy,
    input  logic                     fft_done,
    output logic                     io_wr_en,
    output logic [address_width-1:0] io_wr_address1,
    output logic [address_width-1:0] io_wr_address2,
    output logic [2*word_size-1:0]   io_wr_sample1,
    output logic [2*word_size-1:0]   io_wr_sample2,
    output logic [address_width-1:0] io_rd_address1,
    output logic [address_width-1:0] io_rd_address2,
    input  logic [2*word_size-1:0]   io_rd_sample1,
    input  logic [2*word_size-1:0]   io_rd_sample2,
    output logic                     frame_busy,
    output state_t                   state_dbg
);

    localparam int SW = 2 * word_size;
    localparam int AW = address_width;

    state_t          state, state_next;
    logic [AW-1:0]   in_count;
    logic [AW-1:0]   m_count;
    logic [AW-1:0]   m_next;
    logic            sel;
    logic [SW-1:0]   hold;
    logic [SW-1:0]   buf0, buf1;
    logic [AW-1:0]   rd_addr1, rd_addr2;

    logic            accept, wr_fire, out_fire, last_in, last_pair;
    logic [AW-1:0]   nat1, nat2, rev1, rev2;

    assign accept    = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign last_in   = (in_count == AW'(N - 1));
    assign last_pair = (m_count == AW'(N / 2 - 1));
    assign m_next    = m_count + AW'(1);

    // Pair slot of the sample being accepted: even index and its odd partner.
    assign nat1 = {in_count[AW-1:1], 1'b0};
    assign nat2 = {in_count[AW-1:1], 1'b1};

    addr_bitrev #(.AW(AW)) u_rev1 (.addr(nat1), .rev(rev1));
    addr_bitrev #(.AW(AW)) u_rev2 (.addr(nat2), .rev(rev2));

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD:    if (accept && last_in) state_next = ST_KICK;
            ST_KICK:    state_next = ST_WAIT;
            ST_WAIT:    if (fft_done) state_next = ST_FETCH;
            ST_FETCH:   state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_EMIT;
            ST_EMIT:    if (out_fire && sel) state_next = last_pair ? ST_LOAD : ST_FETCH;
            default:    state_next = ST_LOAD;
        endcase
    end

    // Outputs. in_ready is gated by reset so nothing is accepted while the
    // register file is still being held in reset.
    always_comb begin
        in_ready       = (state == ST_LOAD) && !fft_busy && !reset;
        wr_fire        = accept && in_count[0];
        io_wr_en       = wr_fire;
        io_wr_address1 = '0;
        io_wr_address2 = '0;
        io_wr_sample1  = '0;
        io_wr_sample2  = '0;
        if (wr_fire) begin
            io_wr_address1 = BIT_REVERSE ? rev1 : nat1;
            io_wr_address2 = BIT_REVERSE ? rev2 : nat2;
            io_wr_sample1  = hold;
            io_wr_sample2  = in_sample;
        end
        fft_start  = (state == ST_KICK);
        out_valid  = (state == ST_EMIT);
        out_sample = '0;
        if (state == ST_EMIT) out_sample = sel ? buf1 : buf0;
        frame_busy = !((state == ST_LOAD) && (in_count == '0));
    end

    assign io_rd_address1 = rd_addr1;
    assign io_rd_address2 = rd_addr2;
    assign state_dbg      = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_LOAD;
            in_count <= '0;
            m_count  <= '0;
            sel      <= 1'b0;
            hold     <= '0;
            buf0     <= '0;
            buf1     <= '0;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                // N is a power of two, so the counter wraps to 0 on the last sample.
                in_count <= in_count + AW'(1);
                if (!in_count[0]) hold <= in_sample;
            end
            // Read addresses are loaded on entry to FETCH and then held.
            if (state == ST_WAIT && fft_done) begin
                m_count  <= '0;
                rd_addr1 <= AW'(0);
                rd_addr2 <= AW'(1);
            end
            if (state == ST_CAPTURE) begin
                buf0 <= io_rd_sample1;
                buf1 <= io_rd_sample2;
                sel  <= 1'b0;
            end
            if (state == ST_EMIT && out_fire) begin
                if (!sel) begin
                    sel <= 1'b1;
                end else begin
                    sel <= 1'b0;
                    if (last_pair) begin
                        m_count <= '0;
                    end else begin
                        m_count  <= m_next;
                        rd_addr1 <= {m_next[AW-2:0], 1'b0};
                        rd_addr2 <= {m_next[AW-2:0], 1'b1};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_io_streamer.sv
module tb_fft_io_streamer;
    import fft_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT A: N=8, bit reversed ----------------
    logic        in_valid = 0, in_ready, out_valid, out_ready = 1, fft_start;
    logic        fft_busy = 0, fft_done = 0, io_wr_en, frame_busy;
    logic [31:0] in_sample = 0, out_sample, io_wr_sample1, io_wr_sample2;
    logic [31:0] io_rd_sample1, io_rd_sample2;
    logic [2:0]  io_wr_address1, io_wr_address2, io_rd_address1, io_rd_address2;
    state_t      state_dbg;

    fft_io_streamer #(.N(8), .word_size(16), .BIT_REVERSE(1'b1)) dut (
        .clk(clk), .reset(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
        .fft_start(fft_start), .fft_busy(fft_busy), .fft_done(fft_done),
        .io_wr_en(io_wr_en), .io_wr_address1(io_wr_address1), .io_wr_address2(io_wr_address2),
        .io_wr_sample1(io_wr_sample1), .io_wr_sample2(io_wr_sample2),
        .io_rd_address1(io_rd_address1), .io_rd_address2(io_rd_address2),
        .io_rd_sample1(io_rd_sample1), .io_rd_sample2(io_rd_sample2),
        .frame_busy(frame_busy), .state_dbg(state_dbg)
    );

    // ---------------- DUT B: N=4, natural order ----------------
    logic        b_in_valid = 0, b_in_ready, b_out_valid, b_fft_start, b_io_wr_en, b_frame_busy;
    logic [31:0] b_in_sample = 0, b_out_sample, b_wr_sample1, b_wr_sample2;
    logic [1:0]  b_wr_address1, b_wr_address2, b_rd_address1, b_rd_address2;
    state_t      b_state_dbg;

    fft_io_streamer #(.N(4), .word_size(16), .BIT_REVERSE(1'b0)) dut_b (
        .clk(clk), .reset(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sample(b_in_sample),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_sample(b_out_sample),
        .fft_start(b_fft_start), .fft_busy(1'b0), .fft_done(1'b0),
        .io_wr_en(b_io_wr_en), .io_wr_address1(b_wr_address1), .io_wr_address2(b_wr_address2),
        .io_wr_sample1(b_wr_sample1), .io_wr_sample2(b_wr_sample2),
        .io_rd_address1(b_rd_address1), .io_rd_address2(b_rd_address2),
        .io_rd_sample1(32'd0), .io_rd_sample2(32'd0),
        .frame_busy(b_frame_busy), .state_dbg(b_state_dbg)
    );

    // ---------------- RAM model (1-cycle read latency) ----------------
    logic [31:0] ram [0:7];
    logic        preload = 0;
    initial for (int i = 0; i < 8; i++) ram[i] = 32'hdead_0000 + 32'(i);
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) ram[i] <= 32'(100 + i);
        end else if (io_wr_en) begin
            ram[io_wr_address1] <= io_wr_sample1;
            ram[io_wr_address2] <= io_wr_sample2;
        end
        io_rd_sample1 <= ram[io_rd_address1];
        io_rd_sample2 <= ram[io_rd_address2];
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [69:0] wr_exp_q[$];
    logic [67:0] b_wr_exp_q[$];
    logic [31:0] out_exp_q[$];

    // Reference maps: 3-bit reversal and pair slots in load order.
    int f3 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    function automatic logic [69:0] wr_pack(input int a1, input int a2, input int d1, input int d2);
        return {3'(a1), 3'(a2), 32'(d1), 32'(d2)};
    endfunction

    int          start_cnt = 0, b_start_cnt = 0, last_wr_cyc = 0;
    logic        prev_hold = 0;
    logic [31:0] prev_sample = 0;
    logic [69:0] wexp;
    logic [67:0] bexp;
    logic [31:0] oexp;

    always @(negedge clk) begin
        if (!rst) begin
            if (io_wr_en) begin
                if (wr_exp_q.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    wexp = wr_exp_q.pop_front();
                    check("wr_pair", {io_wr_address1, io_wr_address2, io_wr_sample1, io_wr_sample2}, wexp);
                end
                last_wr_cyc = cyc;
            end
            if (fft_start) begin
                start_cnt++;
                check("start_gap", cyc - last_wr_cyc, 1);
            end
            if (prev_hold) begin
                check("out_hold_valid", out_valid, 1);
                check("out_stable", out_sample, prev_sample);
            end
            if (out_valid && out_ready) begin
                if (out_exp_q.size() == 0) check("out_unexpected", 1, 0);
                else begin
                    oexp = out_exp_q.pop_front();
                    check("out_sample", out_sample, oexp);
                end
            end
            prev_hold   = out_valid & ~out_ready;
            prev_sample = out_sample;
            if (b_io_wr_en) begin
                if (b_wr_exp_q.size() == 0) check("b_wr_unexpected", 1, 0);
                else begin
                    bexp = b_wr_exp_q.pop_front();
                    check("b_wr_pair", {b_wr_address1, b_wr_address2, b_wr_sample1, b_wr_sample2}, bexp);
                end
            end
            if (b_fft_start) b_start_cnt++;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int s);
        logic acc;
        in_valid  = 1'b1;
        in_sample = 32'(s);
        acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic push_load_exp(input int base);
        for (int k = 0; k < 4; k++)
            wr_exp_q.push_back(wr_pack(f3[2*k], f3[2*k+1], base + 2*k, base + 2*k + 1));
    endtask

    task automatic pulse_done();
        fft_done = 1'b1;
        @(posedge clk); #1;
        fft_done = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        for (int t = 0; t < 400 && out_exp_q.size() != 0; t++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
        end
        check("drain_left", out_exp_q.size(), 0);
        out_ready = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fft_start", fft_start, 0);
        check("rst_wr_en", io_wr_en, 0);
        check("rst_frame_busy", frame_busy, 0);
        check("rst_state", state_dbg, ST_LOAD);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // N=4 natural-order instance: pairs (0,1),(2,3)
        b_wr_exp_q.push_back({2'd0, 2'd1, 32'd1, 32'd2});
        b_wr_exp_q.push_back({2'd2, 2'd3, 32'd3, 32'd4});
        for (int k = 0; k < 4; k++) begin
            b_in_valid  = 1'b1;
            b_in_sample = 32'(k + 1);
            @(negedge clk);
            check("b_in_ready", b_in_ready, 1);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("b_wr_left", b_wr_exp_q.size(), 0);
        check("b_start_cnt", b_start_cnt, 1);

        // fft_done while idle in LOAD is ignored
        pulse_done();
        repeat (4) @(posedge clk); #1;
        check("idle_done_state", state_dbg, ST_LOAD);
        check("idle_done_busy", frame_busy, 0);

        // Frame 1: 1..8 back-to-back
        push_load_exp(1);
        for (int i = 0; i < 8; i++) send(1 + i);
        repeat (3) @(posedge clk); #1;
        check("f1_wr_left", wr_exp_q.size(), 0);
        check("f1_start_cnt", start_cnt, 1);
        @(negedge clk);
        check("wait_in_ready", in_ready, 0);
        check("wait_state", state_dbg, ST_WAIT);
        @(posedge clk); #1;
        for (int j = 0; j < 8; j++) out_exp_q.push_back(32'(1 + f3[j]));
        pulse_done();
        drain(1'b0);
        @(negedge clk);
        check("f1_end_in_ready", in_ready, 1);
        check("f1_end_busy", frame_busy, 0);
        @(posedge clk); #1;

        // Frame 2: fft_done and fft_busy mid-LOAD
        push_load_exp(21);
        for (int i = 0; i < 3; i++) send(21 + i);
        pulse_done();
        repeat (2) @(posedge clk); #1;
        check("mid_done_state", state_dbg, ST_LOAD);
        check("mid_done_busy", frame_busy, 1);
        in_valid  = 1'b1;
        in_sample = 32'd24;
        fft_busy  = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("busy_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        fft_busy = 1'b0;
        for (int i = 3; i < 8; i++) send(21 + i);
        repeat (3) @(posedge clk); #1;
        check("f2_wr_left", wr_exp_q.size(), 0);
        check("f2_start_cnt", start_cnt, 2);
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
        for (int j = 0; j < 8; j++) out_exp_q.push_back(32'(100 + j));
        pulse_done();
        drain(1'b1);
        @(negedge clk);
        check("f2_end_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Frame 3: reset while emitting
        push_load_exp(31);
        for (int i = 0; i < 8; i++) send(31 + i);
        repeat (2) @(posedge clk); #1;
        for (int j = 0; j < 8; j++) out_exp_q.push_back(32'(31 + f3[j]));
        pulse_done();
        for (int t = 0; t < 100 && out_exp_q.size() > 5; t++) begin
            @(posedge clk); #1;
        end
        check("f3_state_emit", state_dbg, ST_EMIT);
        rst = 1'b1;
        #1;
        check("rst_emit_out_valid", out_valid, 0);
        check("rst_emit_out_sample", out_sample, 0);
        check("rst_emit_in_ready", in_ready, 0);
        check("rst_emit_wr_en", io_wr_en, 0);
        check("rst_emit_start", fft_start, 0);
        check("rst_emit_busy", frame_busy, 0);
        check("rst_emit_rd_addr", {io_rd_address1, io_rd_address2}, 0);
        out_exp_q.delete();
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst2_in_ready", in_ready, 1);
        check("post_rst2_state", state_dbg, ST_LOAD);
        check("final_wr_left", wr_exp_q.size(), 0);
        check("final_start_cnt", start_cnt, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
